// File: rtl/fc_pkg.sv
// Shared types, default sizes and the requantise/saturate helper for the
// fully-connected MAC engine.
package fc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMPUTE,
        EMIT
    } fc_state_e;

    localparam int unsigned DEF_IN_SIZE     = 512;
    localparam int unsigned DEF_OUT_SIZE    = 64;
    localparam int unsigned DEF_WEIGHT_BITS = 8;
    localparam int unsigned DEF_ACTIV_BITS  = 8;
    localparam int unsigned DEF_ACC_BITS    = 32;
    localparam int unsigned DEF_FRAC_BITS   = 7;

    // Index width that stays at least one bit for degenerate sizes.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Floor shift, optional ReLU, then clamp to a signed abits-wide range.
    function automatic logic signed [63:0] requant(
        input logic signed [63:0] acc,
        input int unsigned        frac,
        input int unsigned        abits,
        input logic               relu
    );
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r  = acc >>> frac;
        hi = (64'sd1 <<< (abits - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (abits - 1));
        if (relu && (r < 64'sd0)) r = '0;
        if (r > hi)      r = hi;
        else if (r < lo) r = lo;
        return r;
    endfunction

endpackage

// File: rtl/fc_mac_engine_if.sv
// Input stream, weight-memory port and output stream of the FC MAC engine.
interface fc_mac_engine_if
    import fc_pkg::*;
#(
    parameter int unsigned IN_SIZE     = DEF_IN_SIZE,
    parameter int unsigned OUT_SIZE    = DEF_OUT_SIZE,
    parameter int unsigned WEIGHT_BITS = DEF_WEIGHT_BITS,
    parameter int unsigned ACTIV_BITS  = DEF_ACTIV_BITS
) ();

    localparam int unsigned AW = idx_w(IN_SIZE * OUT_SIZE);
    localparam int unsigned OW = idx_w(OUT_SIZE);

    logic signed [ACTIV_BITS-1:0]  in_data;
    logic                          in_valid;
    logic                          in_ready;
    logic                          w_rd_en;
    logic [AW-1:0]                 w_addr;
    logic signed [WEIGHT_BITS-1:0] w_data;
    logic signed [ACTIV_BITS-1:0]  out_data;
    logic [OW-1:0]                 out_index;
    logic                          out_valid;
    logic                          out_ready;

    modport slave (
        input  in_data, in_valid, w_data, out_ready,
        output in_ready, w_rd_en, w_addr, out_data, out_index, out_valid
    );

    modport master (
        output in_data, in_valid, w_data, out_ready,
        input  in_ready, w_rd_en, w_addr, out_data, out_index, out_valid
    );

endinterface

// File: rtl/fc_mac_unit.sv
// Signed multiply-accumulate datapath with bias preload and requantised result.
module fc_mac_unit
    import fc_pkg::*;
#(
    parameter int unsigned WEIGHT_BITS = DEF_WEIGHT_BITS,
    parameter int unsigned ACTIV_BITS  = DEF_ACTIV_BITS,
    parameter int unsigned ACC_BITS    = DEF_ACC_BITS,
    parameter int unsigned FRAC_BITS   = DEF_FRAC_BITS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          init,
    input  logic                          acc_en,
    input  logic                          relu,
    input  logic signed [ACTIV_BITS-1:0]  bias,
    input  logic signed [ACTIV_BITS-1:0]  x,
    input  logic signed [WEIGHT_BITS-1:0] w,
    output logic signed [ACTIV_BITS-1:0]  result
);

    localparam int unsigned PW = WEIGHT_BITS + ACTIV_BITS;

    logic signed [ACC_BITS-1:0] acc_q;
    logic signed [ACC_BITS-1:0] acc_d;
    logic signed [PW-1:0]       prod;

    always_comb begin
        prod  = PW'(x) * PW'(w);
        acc_d = acc_q;
        if (init) begin
            acc_d = ACC_BITS'(bias) <<< FRAC_BITS;
        end else if (acc_en) begin
            acc_d = acc_q + ACC_BITS'(prod);
        end
        result = ACTIV_BITS'(requant(64'(acc_q), FRAC_BITS, ACTIV_BITS, relu));
    end

    always_ff @(posedge clk) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end

endmodule

// File: rtl/fc_mac_engine.sv
// Fully-connected layer engine: buffers one input frame, then computes each
// neuron by streaming its weights from external memory through fc_mac_unit.
module fc_mac_engine
    import fc_pkg::*;
#(
    parameter int unsigned IN_SIZE     = DEF_IN_SIZE,
    parameter int unsigned OUT_SIZE    = DEF_OUT_SIZE,
    parameter int unsigned WEIGHT_BITS = DEF_WEIGHT_BITS,
    parameter int unsigned ACTIV_BITS  = DEF_ACTIV_BITS,
    parameter int unsigned ACC_BITS    = DEF_ACC_BITS,
    parameter int unsigned FRAC_BITS   = DEF_FRAC_BITS
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           relu_en,
    input  logic [OUT_SIZE*ACTIV_BITS-1:0] biases,
    output logic                           busy,
    output logic                           done,
    fc_mac_engine_if.slave                 bus
);

    localparam int unsigned XW = idx_w(IN_SIZE);
    localparam int unsigned JW = idx_w(IN_SIZE + 2);
    localparam int unsigned OW = idx_w(OUT_SIZE);
    localparam int unsigned AW = idx_w(IN_SIZE * OUT_SIZE);
    localparam logic [XW-1:0] LAST_X  = XW'(IN_SIZE - 1);
    localparam logic [JW-1:0] LAST_RD = JW'(IN_SIZE - 1);
    localparam logic [JW-1:0] LAST_J  = JW'(IN_SIZE + 1);
    localparam logic [OW-1:0] LAST_O  = OW'(OUT_SIZE - 1);

    fc_state_e                   state_q, state_d;
    logic [XW-1:0]               cnt_q, cnt_d;
    logic [JW-1:0]               j_q, j_d;
    logic [OW-1:0]               o_q, o_d;
    logic                        relu_q, relu_d;
    logic                        w_rd_en_q, w_rd_en_d;
    logic [AW-1:0]               w_addr_q, w_addr_d;
    logic                        mac_vld_q, mac_vld_d;
    logic [XW-1:0]               x_sel_q, x_sel_d;
    logic signed [ACTIV_BITS-1:0] out_data_q, out_data_d;
    logic                        out_valid_q, out_valid_d;
    logic                        done_q, done_d;

    logic signed [ACTIV_BITS-1:0] buf_q [IN_SIZE];
    logic                         buf_wr;
    logic [XW-1:0]                buf_idx;
    logic                         in_ready;
    logic                         xfer;
    logic signed [ACTIV_BITS-1:0] bias_sel;
    logic signed [ACTIV_BITS-1:0] mac_result;

    assign in_ready = (state_q == IDLE) || (state_q == LOAD);
    assign xfer     = bus.in_valid && in_ready;
    assign bias_sel = biases[o_q*ACTIV_BITS +: ACTIV_BITS];

    // w_data for a read issued with index x_sel lands one cycle later, so the
    // buffer operand is selected by the delayed index.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        j_d         = j_q;
        o_d         = o_q;
        relu_d      = relu_q;
        w_rd_en_d   = 1'b0;
        w_addr_d    = w_addr_q;
        mac_vld_d   = w_rd_en_q;
        x_sel_d     = XW'(j_q);
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        buf_wr      = 1'b0;
        buf_idx     = cnt_q;
        unique case (state_q)
            IDLE: if (xfer) begin
                buf_wr  = 1'b1;
                buf_idx = '0;
                relu_d  = relu_en;
                o_d     = '0;
                if (IN_SIZE == 1) begin
                    state_d   = COMPUTE;
                    j_d       = '0;
                    w_rd_en_d = 1'b1;
                    w_addr_d  = '0;
                end else begin
                    state_d = LOAD;
                    cnt_d   = XW'(1);
                end
            end
            LOAD: if (xfer) begin
                buf_wr = 1'b1;
                if (cnt_q == LAST_X) begin
                    state_d   = COMPUTE;
                    j_d       = '0;
                    o_d       = '0;
                    w_rd_en_d = 1'b1;
                    w_addr_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            COMPUTE: begin
                j_d = j_q + 1'b1;
                if (j_q < LAST_RD) begin
                    w_rd_en_d = 1'b1;
                    w_addr_d  = w_addr_q + 1'b1;
                end
                if (j_q == LAST_J) begin
                    state_d     = EMIT;
                    out_data_d  = mac_result;
                    out_valid_d = 1'b1;
                end
            end
            EMIT: if (bus.out_ready) begin
                out_valid_d = 1'b0;
                if (o_q == LAST_O) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    o_d       = o_q + 1'b1;
                    state_d   = COMPUTE;
                    j_d       = '0;
                    w_rd_en_d = 1'b1;
                    w_addr_d  = w_addr_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            j_q         <= '0;
            o_q         <= '0;
            relu_q      <= 1'b0;
            w_rd_en_q   <= 1'b0;
            w_addr_q    <= '0;
            mac_vld_q   <= 1'b0;
            x_sel_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            j_q         <= j_d;
            o_q         <= o_d;
            relu_q      <= relu_d;
            w_rd_en_q   <= w_rd_en_d;
            w_addr_q    <= w_addr_d;
            mac_vld_q   <= mac_vld_d;
            x_sel_q     <= x_sel_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_wr) buf_q[buf_idx] <= bus.in_data;
    end

    fc_mac_unit #(
        .WEIGHT_BITS (WEIGHT_BITS),
        .ACTIV_BITS  (ACTIV_BITS),
        .ACC_BITS    (ACC_BITS),
        .FRAC_BITS   (FRAC_BITS)
    ) u_mac (
        .clk    (clk),
        .rst    (rst),
        .init   ((state_q == COMPUTE) && (j_q == '0)),
        .acc_en (mac_vld_q),
        .relu   (relu_q),
        .bias   (bias_sel),
        .x      (buf_q[x_sel_q]),
        .w      (bus.w_data),
        .result (mac_result)
    );

    assign bus.in_ready  = in_ready;
    assign bus.w_rd_en   = w_rd_en_q;
    assign bus.w_addr    = w_addr_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_index = o_q;
    assign bus.out_valid = out_valid_q;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;

endmodule
